// File: rtl/aes_ctrl_pkg.sv
// Shared types and helpers for the AES controller slice: FSM state encoding,
// key-length codes and AHB shift-direction constants.
package aes_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_KEY,
        CHG_KEY,
        FETCH_BLK,
        ENC,
        WAIT,
        WRITE,
        ERROR
    } state_t;

    typedef enum logic [1:0] {
        KEY_128 = 2'b00,
        KEY_192 = 2'b01,
        KEY_256 = 2'b10,
        KEY_BAD = 2'b11
    } keylen_t;

    localparam logic AHB_IN  = 1'b0;
    localparam logic AHB_OUT = 1'b1;

    // Number of 32-bit key words delivered for each key length.
    function automatic logic [3:0] key_words(input keylen_t kl);
        case (kl)
            KEY_128: return 4'd4;
            KEY_192: return 4'd6;
            KEY_256: return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

endpackage

// File: rtl/aes_beat_ctr.sv
// Beat counter with sync clear, parallel load and saturation at a terminal value.
// Priority: reset/clear, then load, then increment.
module aes_beat_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] term_val,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != term_val)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/aes_ctrl_pipe.sv
// AES controller sequencing AHB beats, GenKey loading and AESctr runs with a
// one-block prefetch buffer. Optional watchdog enabled by AES_CTRL_TIMEOUT_EN.
module aes_ctrl_pipe
    import aes_ctrl_pkg::*;
#(
    parameter int BLK_WORDS   = 4,
    parameter int CNT_W       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             data_received,
    input  logic             data_type,
    input  logic             enc_dec,
    input  logic [1:0]       key_len,
    input  logic             chg_key_done,
    input  logic             enc_done,
    output logic             opt_mode,
    output logic             load_key,
    output logic             aes_load,
    output logic             aes_enable,
    output logic             ahb_mode,
    output logic             ahb_shift_en,
    output logic             done_chg_key,
    output logic [CNT_W-1:0] word_idx,
    output logic             busy,
    output logic             error
);

    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLK_WORDS - 1);
    localparam logic [CNT_W-1:0] BLK_FULL = CNT_W'(BLK_WORDS);
    localparam logic [CNT_W-1:0] IDX_MAX  = {CNT_W{1'b1}};

    state_t           state;
    state_t           state_nxt;
    keylen_t          key_len_q;
    logic [CNT_W-1:0] key_last;
    logic [CNT_W-1:0] pf_cnt;

    logic key_last_beat;
    logic blk_last_beat;
    logic wr_last;
    logic pf_beat;
    logic pf_full;
    logic pf_partial;

    logic idx_en;
    logic idx_clr;
    logic idx_load;
    logic pf_en;
    logic pf_clr;
    logic wd_expired;

    assign key_last      = CNT_W'(key_words(key_len_q) - 4'd1);
    assign key_last_beat = (state == FETCH_KEY) && data_received && (word_idx == key_last);
    assign blk_last_beat = (state == FETCH_BLK) && data_received && (word_idx == BLK_LAST);
    assign wr_last       = (state == WRITE) && (word_idx == BLK_LAST);
    assign pf_full       = (pf_cnt == BLK_FULL);
    assign pf_partial    = (pf_cnt != '0) && !pf_full;

    // Prefetch only accepts data words while AESctr is busy; key words wait for IDLE.
    assign pf_beat = (state == WAIT) && start && !data_type && data_received && !pf_full;

`ifdef AES_CTRL_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clk) begin
        if (rst || (state_nxt != state)) begin
            wd_cnt <= '0;
        end else if (wd_cnt != WD_LAST) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    assign wd_expired = (wd_cnt == WD_LAST);
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (!data_type) begin
                        state_nxt = FETCH_BLK;
                    end else if (keylen_t'(key_len) == KEY_BAD) begin
                        state_nxt = ERROR;
                    end else begin
                        state_nxt = FETCH_KEY;
                    end
                end
            end
            FETCH_KEY: begin
                if (key_last_beat) state_nxt = CHG_KEY;
            end
            CHG_KEY: begin
                if (chg_key_done)    state_nxt = IDLE;
                else if (wd_expired) state_nxt = ERROR;
            end
            FETCH_BLK: begin
                if (blk_last_beat) state_nxt = ENC;
            end
            ENC: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (enc_done)        state_nxt = WRITE;
                else if (wd_expired) state_nxt = ERROR;
            end
            WRITE: begin
                // A full prefetch buffer goes straight back to AESctr.
                if (wr_last) begin
                    if (pf_full)         state_nxt = ENC;
                    else if (pf_partial) state_nxt = FETCH_BLK;
                    else                 state_nxt = IDLE;
                end
            end
            ERROR: begin
                if (!start) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        idx_en   = 1'b0;
        idx_clr  = 1'b0;
        idx_load = 1'b0;
        pf_en    = pf_beat;
        pf_clr   = wr_last || (state == ERROR) || (state == IDLE);
        case (state)
            FETCH_KEY: begin
                idx_en  = data_received;
                idx_clr = key_last_beat;
            end
            FETCH_BLK: begin
                idx_en  = data_received;
                idx_clr = blk_last_beat;
            end
            WRITE: begin
                idx_en   = 1'b1;
                idx_load = wr_last && pf_partial;
                idx_clr  = wr_last && !pf_partial;
            end
            IDLE, ERROR: begin
                idx_clr = 1'b1;
            end
            default: begin
                idx_en = 1'b0;
            end
        endcase
    end

    aes_beat_ctr #(.W(CNT_W)) u_idx_ctr (
        .clk      (clk),
        .rst      (rst),
        .en       (idx_en),
        .clr      (idx_clr),
        .load     (idx_load),
        .load_val (pf_cnt),
        .term_val (IDX_MAX),
        .count    (word_idx)
    );

    aes_beat_ctr #(.W(CNT_W)) u_pf_ctr (
        .clk      (clk),
        .rst      (rst),
        .en       (pf_en),
        .clr      (pf_clr),
        .load     (1'b0),
        .load_val ('0),
        .term_val (BLK_FULL),
        .count    (pf_cnt)
    );

    // Mode and key length are captured when a request leaves IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            opt_mode     <= 1'b0;
            key_len_q    <= KEY_128;
            done_chg_key <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                opt_mode  <= enc_dec;
                key_len_q <= keylen_t'(key_len);
            end
            done_chg_key <= (state == CHG_KEY) && chg_key_done;
        end
    end

    always_comb begin
        load_key     = 1'b0;
        aes_load     = 1'b0;
        aes_enable   = 1'b0;
        ahb_mode     = AHB_IN;
        ahb_shift_en = 1'b0;
        busy         = (state != IDLE);
        error        = 1'b0;
        case (state)
            FETCH_KEY: ahb_shift_en = data_received && (word_idx <= key_last);
            CHG_KEY:   load_key     = 1'b1;
            FETCH_BLK: ahb_shift_en = data_received && (word_idx <= BLK_LAST);
            ENC: begin
                aes_load   = 1'b1;
                aes_enable = 1'b1;
            end
            WAIT: begin
                aes_enable   = 1'b1;
                ahb_shift_en = pf_beat;
            end
            WRITE: begin
                ahb_mode     = AHB_OUT;
                ahb_shift_en = 1'b1;
            end
            ERROR:   error = 1'b1;
            default: load_key = 1'b0;
        endcase
    end

endmodule
